// File: rtl/subkey_h_powers_reader.sv
// Subkey H powers reader: snapshots the H^1..H^MAX_POWER bus and serves powers as a stream or as
// indexed reads. Define SUBKEY_READER_ZEROIZE_EN to clear key material on reset and invalidation.
module subkey_h_powers_reader #(
    parameter int unsigned NB_DATA   = 128,
    parameter int unsigned MAX_POWER = 2,
    parameter int unsigned NB_INDEX  = 8
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic [MAX_POWER*NB_DATA-1:0] i_h_power_bus,
    input  logic                         i_powers_ready,
    input  logic                         i_valid,
    input  logic                         i_start,
    input  logic                         i_req,
    input  logic [NB_INDEX-1:0]          i_req_index,
    input  logic                         i_ready,
    output logic [NB_DATA-1:0]           o_power,
    output logic [NB_INDEX-1:0]          o_power_index,
    output logic                         o_power_valid,
    output logic                         o_loaded,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_req_error,
    output logic                         o_abort
);

`ifdef SUBKEY_READER_ZEROIZE_EN
    localparam bit Zeroize = 1'b1;
`else
    localparam bit Zeroize = 1'b0;
`endif

    if (NB_DATA != 128 || MAX_POWER < 1 || (NB_INDEX < 31 && (2 ** NB_INDEX) <= MAX_POWER))
    begin : g_bad_config
        $error("subkey_h_powers_reader: unsupported parameter combination");
    end

    typedef enum logic [1:0] {StEmpty, StLoaded, StStream, StSingle} state_e;

    state_e                         state_q, state_d;
    logic                           ready_q;
    logic [MAX_POWER*NB_DATA-1:0]   snap_q, snap_d, src;
    logic [NB_DATA-1:0]             power_q, power_d;
    logic [NB_INDEX-1:0]            index_q, index_d;
    logic                           valid_q, valid_d, loaded_q, loaded_d;
    logic                           done_q, done_d, err_q, err_d, abort_q, abort_d;
    logic                           rise, fall, take, req_ok;

    function automatic logic [NB_DATA-1:0] pick(input logic [MAX_POWER*NB_DATA-1:0] bus,
                                                input logic [NB_INDEX-1:0]          k);
        pick = '0;
        for (int unsigned j = 1; j <= MAX_POWER; j++) begin
            if (k == NB_INDEX'(j)) pick = bus[j*NB_DATA-1 -: NB_DATA];
        end
    endfunction

    assign rise   = i_powers_ready & ~ready_q;
    assign fall   = ~i_powers_ready & ready_q;
    // i_valid qualification is applied at the registers, so it is left out here.
    assign take   = valid_q & i_ready;
    assign req_ok = (i_req_index != '0) && (i_req_index <= NB_INDEX'(MAX_POWER));

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        power_d  = power_q;
        index_d  = index_q;
        valid_d  = valid_q;
        loaded_d = loaded_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        abort_d  = 1'b0;
        src      = snap_q;
        unique case (state_q)
            StEmpty: begin
                if (rise) begin
                    snap_d   = i_h_power_bus;
                    loaded_d = 1'b1;
                    state_d  = StLoaded;
                end
                if (i_start || i_req) err_d = 1'b1;
            end
            StLoaded: begin
                if (fall) begin
                    loaded_d = 1'b0;
                    state_d  = StEmpty;
                    err_d    = i_start | i_req;
                    if (Zeroize) begin
                        snap_d  = '0;
                        power_d = '0;
                    end
                end else begin
                    // A request coinciding with a re-capture is served from the fresh bus.
                    if (rise) begin
                        snap_d = i_h_power_bus;
                        src    = i_h_power_bus;
                    end
                    if (i_start) begin
                        index_d = NB_INDEX'(1);
                        power_d = pick(src, NB_INDEX'(1));
                        valid_d = 1'b1;
                        state_d = StStream;
                    end else if (i_req) begin
                        if (req_ok) begin
                            index_d = i_req_index;
                            power_d = pick(src, i_req_index);
                            valid_d = 1'b1;
                            state_d = StSingle;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            StStream, StSingle: begin
                if (fall || rise) begin
                    valid_d  = 1'b0;
                    abort_d  = 1'b1;
                    loaded_d = 1'b0;
                    state_d  = StEmpty;
                    if (Zeroize) begin
                        snap_d  = '0;
                        power_d = '0;
                    end
                end else if (take) begin
                    if (state_q == StSingle || index_q == NB_INDEX'(MAX_POWER)) begin
                        valid_d = 1'b0;
                        done_d  = (state_q == StStream);
                        state_d = StLoaded;
                    end else begin
                        index_d = index_q + NB_INDEX'(1);
                        power_d = pick(snap_q, index_q + NB_INDEX'(1));
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= StEmpty;
            ready_q  <= 1'b0;
            power_q  <= '0;
            index_q  <= '0;
            valid_q  <= 1'b0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
        end else if (i_valid) begin
            state_q  <= state_d;
            ready_q  <= i_powers_ready;
            power_q  <= power_d;
            index_q  <= index_d;
            valid_q  <= valid_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
            err_q    <= err_d;
            abort_q  <= abort_d;
        end
    end

    // The snapshot is only wiped by reset when zeroization is enabled.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            if (Zeroize) snap_q <= '0;
        end else if (i_valid) begin
            snap_q <= snap_d;
        end
    end

    assign o_power       = power_q;
    assign o_power_index = index_q;
    assign o_power_valid = valid_q;
    assign o_loaded      = loaded_q;
    assign o_busy        = (state_q == StStream) || (state_q == StSingle);
    assign o_done        = done_q;
    assign o_req_error   = err_q;
    assign o_abort       = abort_q;

endmodule

// File: tb/tb_subkey_h_powers_reader.sv
// Self-checking bench for subkey_h_powers_reader with MAX_POWER=4 against a table model of the
// captured powers and an expected-exponent scoreboard.
module tb_subkey_h_powers_reader;

    localparam int unsigned NB_DATA   = 128;
    localparam int unsigned MAX_POWER = 4;
    localparam int unsigned NB_INDEX  = 8;

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic [MAX_POWER*NB_DATA-1:0] bus = '0;
    logic                         pready = 1'b0, vld = 1'b0, start = 1'b0, req = 1'b0;
    logic [NB_INDEX-1:0]          req_idx = '0;
    logic                         rdy = 1'b0;
    logic [NB_DATA-1:0]           power;
    logic [NB_INDEX-1:0]          pidx;
    logic                         pvalid, loaded, busy, done, rerr, abort;

    logic [NB_DATA-1:0] ref_pow [1:MAX_POWER];
    int vectors = 0;
    int errors  = 0;

    subkey_h_powers_reader #(
        .NB_DATA  (NB_DATA),
        .MAX_POWER(MAX_POWER),
        .NB_INDEX (NB_INDEX)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_h_power_bus (bus),
        .i_powers_ready(pready),
        .i_valid       (vld),
        .i_start       (start),
        .i_req         (req),
        .i_req_index   (req_idx),
        .i_ready       (rdy),
        .o_power       (power),
        .o_power_index (pidx),
        .o_power_valid (pvalid),
        .o_loaded      (loaded),
        .o_busy        (busy),
        .o_done        (done),
        .o_req_error   (rerr),
        .o_abort       (abort)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input bit random);
        logic [3:0] kk;
        for (int k = 1; k <= MAX_POWER; k++) begin
            kk = 4'(k);
            ref_pow[k] = random ? {$urandom, $urandom, $urandom, $urandom} : {32{kk}};
            bus[k*NB_DATA-1 -: NB_DATA] = ref_pow[k];
        end
    endtask

    // Drop then raise the generator ready so the reader takes a fresh random snapshot.
    task automatic reload();
        pready = 1'b0;
        step();
        set_bus(1'b1);
        pready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vld = 1'b1;
        step();
        step();
        rst = 1'b0;
        vectors++; if (pvalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pvalid); end
        vectors++; if (power !== '0) begin errors++; $display("FAIL reset_power got %h want 0", power); end
        vectors++; if (pidx !== '0) begin errors++; $display("FAIL reset_index got %0d want 0", pidx); end
        vectors++; if ({loaded, busy, done, rerr, abort} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {loaded, busy, done, rerr, abort});
        end
    endtask

    task automatic test_empty_request();
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++; if (rerr !== 1'b1) begin errors++; $display("FAIL empty_err got %b want 1", rerr); end
        vectors++; if (pvalid !== 1'b0) begin errors++; $display("FAIL empty_valid got %b want 0", pvalid); end
        step();
        vectors++; if (rerr !== 1'b0) begin errors++; $display("FAIL empty_err_pulse got %b want 0", rerr); end
    endtask

    task automatic test_load_and_stream();
        set_bus(1'b0);
        pready = 1'b1;
        step();
        vectors++; if (loaded !== 1'b1) begin errors++; $display("FAIL load_loaded got %b want 1", loaded); end
        start = 1'b1;
        rdy   = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= MAX_POWER; k++) begin
            vectors++; if (pvalid !== 1'b1 || pidx !== NB_INDEX'(k) || power !== ref_pow[k]) begin
                errors++; $display("FAIL stream_k%0d got v=%b i=%0d p=%h want v=1 i=%0d p=%h",
                                   k, pvalid, pidx, power, k, ref_pow[k]);
            end
            vectors++; if (done !== 1'b0) begin errors++; $display("FAIL stream_early_done k=%0d got 1 want 0", k); end
            step();
        end
        vectors++; if ({done, pvalid, busy, loaded} !== 4'b1001) begin
            errors++; $display("FAIL stream_end got done/valid/busy/loaded=%b want 1001",
                               {done, pvalid, busy, loaded});
        end
        step();
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got 1 want 0"); end
    endtask

    task automatic test_backpressure();
        int exp_k = 1, taken = 0, stall = 0;
        bit took_last;
        reload();
        rdy   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 60 && exp_k <= MAX_POWER; cyc++) begin
            vectors++; if (pvalid !== 1'b1 || pidx !== NB_INDEX'(exp_k) || power !== ref_pow[exp_k]) begin
                errors++; $display("FAIL bp_out cyc=%0d got v=%b i=%0d p=%h want v=1 i=%0d p=%h",
                                   cyc, pvalid, pidx, power, exp_k, ref_pow[exp_k]);
            end
            if (exp_k == 2 && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            took_last = rdy && exp_k == MAX_POWER;
            if (rdy) begin
                taken++;
                exp_k++;
            end
            step();
            vectors++; if (done !== took_last) begin
                errors++; $display("FAIL bp_done got %b want %b", done, took_last);
            end
        end
        vectors++; if (taken != MAX_POWER || pvalid !== 1'b0 || stall != 3) begin
            errors++; $display("FAIL bp_total got takes=%0d valid=%b stalls=%0d want %0d 0 3",
                               taken, pvalid, stall, MAX_POWER);
        end
        rdy = 1'b1;
    endtask

    task automatic test_single();
        int k;
        bit ok;
        for (int n = 0; n < 12; n++) begin
            k = (n == 0) ? 3 : (n == 1) ? 0 : (n == 2) ? 5 : int'($urandom_range(0, 9));
            ok = k >= 1 && k <= MAX_POWER;
            req = 1'b1;
            req_idx = NB_INDEX'(k);
            step();
            req = 1'b0;
            if (ok) begin
                vectors++; if (pvalid !== 1'b1 || pidx !== NB_INDEX'(k) || power !== ref_pow[k] ||
                               busy !== 1'b1 || rerr !== 1'b0) begin
                    errors++; $display("FAIL single_k%0d got v=%b i=%0d p=%h busy=%b err=%b want v=1 i=%0d p=%h",
                                       k, pvalid, pidx, power, busy, rerr, k, ref_pow[k]);
                end
                step();
                vectors++; if (pvalid !== 1'b0 || busy !== 1'b0 || loaded !== 1'b1) begin
                    errors++; $display("FAIL single_after_k%0d got v=%b busy=%b loaded=%b want 0 0 1",
                                       k, pvalid, busy, loaded);
                end
            end else begin
                vectors++; if (rerr !== 1'b1 || pvalid !== 1'b0 || busy !== 1'b0 || loaded !== 1'b1) begin
                    errors++; $display("FAIL single_bad_k%0d got err=%b v=%b busy=%b loaded=%b want 1 0 0 1",
                                       k, rerr, pvalid, busy, loaded);
                end
            end
        end
        step();
    endtask

    task automatic test_abort();
        reload();
        rdy   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        vectors++; if (pidx !== NB_INDEX'(3)) begin errors++; $display("FAIL abort_setup got i=%0d want 3", pidx); end
        rdy    = 1'b0;
        pready = 1'b0;
        step();
        vectors++; if ({abort, pvalid, loaded, busy} !== 4'b1000) begin
            errors++; $display("FAIL abort_flags got abort/valid/loaded/busy=%b want 1000",
                               {abort, pvalid, loaded, busy});
        end
`ifdef SUBKEY_READER_ZEROIZE_EN
        vectors++; if (power !== '0) begin errors++; $display("FAIL abort_zeroize got %h want 0", power); end
`endif
        step();
        vectors++; if (abort !== 1'b0) begin errors++; $display("FAIL abort_pulse got 1 want 0"); end
        set_bus(1'b1);
        pready = 1'b1;
        step();
        rdy   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= MAX_POWER; k++) begin
            vectors++; if (pvalid !== 1'b1 || pidx !== NB_INDEX'(k) || power !== ref_pow[k]) begin
                errors++; $display("FAIL restream_k%0d got v=%b i=%0d p=%h want v=1 i=%0d p=%h",
                                   k, pvalid, pidx, power, k, ref_pow[k]);
            end
            step();
        end
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL restream_done got 0 want 1"); end
    endtask

    task automatic test_gating_reset();
        reload();
        rdy   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        vld = 1'b0;
        for (int c = 0; c < 5; c++) begin
            rdy   = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            req   = 1'($urandom_range(0, 1));
            step();
            vectors++; if (pvalid !== 1'b1 || pidx !== NB_INDEX'(2) || power !== ref_pow[2] ||
                           busy !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL gate_c%0d got v=%b i=%0d p=%h busy=%b want v=1 i=2 p=%h",
                                   c, pvalid, pidx, power, busy, ref_pow[2]);
            end
        end
        vld   = 1'b1;
        rdy   = 1'b1;
        start = 1'b0;
        req   = 1'b0;
        step();
        vectors++; if (pidx !== NB_INDEX'(3) || power !== ref_pow[3]) begin
            errors++; $display("FAIL gate_resume got i=%0d p=%h want i=3 p=%h", pidx, power, ref_pow[3]);
        end
        rst    = 1'b1;
        pready = 1'b0;
        step();
        rst = 1'b0;
        vectors++; if ({pvalid, loaded, busy, done, rerr, abort} !== 6'b0 || power !== '0 || pidx !== '0) begin
            errors++; $display("FAIL midreset got flags=%b i=%0d p=%h want 0",
                               {pvalid, loaded, busy, done, rerr, abort}, pidx, power);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++; if ({rerr, pvalid, loaded} !== 3'b100) begin
            errors++; $display("FAIL post_reset_empty got err/valid/loaded=%b want 100", {rerr, pvalid, loaded});
        end
    endtask

    initial begin
        test_reset();
        test_empty_request();
        test_load_and_stream();
        test_backpressure();
        test_single();
        test_abort();
        test_gating_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
